// File: rtl/id_ex_pipe_pkg.sv
// rtl/id_ex_pipe_pkg.sv - shared constants and bus widths for the ID/EX stage
package id_ex_pipe_pkg;

    localparam int ALU_OP_BUS   = 8;
    localparam int ALU_SEL_BUS  = 3;
    localparam int REG_BUS      = 32;
    localparam int REG_ADDR_BUS = 5;

    localparam logic                    ENABLE       = 1'b1;
    localparam logic                    DISABLE      = 1'b0;
    localparam logic [ALU_OP_BUS-1:0]   EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [ALU_SEL_BUS-1:0]  EXE_RES_NOP  = 3'b000;
    localparam logic [REG_ADDR_BUS-1:0] NOP_REG_ADDR = 5'b00000;
    localparam logic [REG_BUS-1:0]      ZERO_32      = 32'h0000_0000;

endpackage

// File: rtl/id_ex_pipe_fifo.sv
// rtl/id_ex_pipe_fifo.sv - generic synchronous FIFO with explicit pointer wrap (pipe_fifo)
module pipe_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // DEPTH need not be a power of two, so pointers wrap by compare, not by masking
    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wrap_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = wrap_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - elastic ID/EX pipeline buffer with flush, x0 suppression and NOP fill
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 8,
    parameter int ALU_SEL_W  = 3,
    parameter int DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       id_valid,
    output logic                       id_ready,
    input  logic [ALU_OP_W-1:0]        id_aluop,
    input  logic [ALU_SEL_W-1:0]       id_alusel,
    input  logic [XLEN-1:0]            id_reg1,
    input  logic [XLEN-1:0]            id_reg2,
    input  logic [REG_ADDR_W-1:0]      id_wd,
    input  logic                       id_wreg,
    output logic                       ex_valid,
    input  logic                       ex_ready,
    output logic [ALU_OP_W-1:0]        ex_aluop,
    output logic [ALU_SEL_W-1:0]       ex_alusel,
    output logic [XLEN-1:0]            ex_reg1,
    output logic [XLEN-1:0]            ex_reg2,
    output logic [REG_ADDR_W-1:0]      ex_wd,
    output logic                       ex_wreg,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = ALU_OP_W + ALU_SEL_W + 2*XLEN + REG_ADDR_W + 1;

    logic          push, pop, full, empty, wreg_eff;
    logic [PW-1:0] din, dout;

    // x0 is hardwired zero, so a write to it is dropped before it is stored
    assign wreg_eff = id_wreg && (id_wd != '0);
    assign din      = {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, wreg_eff};

    assign id_ready = !full;
    assign ex_valid = !empty;
    assign push     = id_valid && !full && !flush;
    assign pop      = ex_ready && !empty && !flush;

    pipe_fifo #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        ex_aluop  = ALU_OP_W'(EXE_NOP_OP);
        ex_alusel = ALU_SEL_W'(EXE_RES_NOP);
        ex_reg1   = XLEN'(ZERO_32);
        ex_reg2   = XLEN'(ZERO_32);
        ex_wd     = REG_ADDR_W'(NOP_REG_ADDR);
        ex_wreg   = DISABLE;
        if (!empty) begin
            {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg} = dout;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - self-checking bench for id_ex_pipe (DEPTH 2 and DEPTH 3)
module tb_id_ex_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DEPTH = 2 instance
    logic        flush2, id_valid2, id_ready2, id_wreg2, ex_valid2, ex_ready2, ex_wreg2;
    logic [7:0]  id_aluop2, ex_aluop2;
    logic [2:0]  id_alusel2, ex_alusel2;
    logic [31:0] id_reg1_2, id_reg2_2, ex_reg1_2, ex_reg2_2;
    logic [4:0]  id_wd2, ex_wd2;
    logic [1:0]  count2;

    // DEPTH = 3 instance
    logic        flush3, id_valid3, id_ready3, id_wreg3, ex_valid3, ex_ready3, ex_wreg3;
    logic [7:0]  id_aluop3, ex_aluop3;
    logic [2:0]  id_alusel3, ex_alusel3;
    logic [31:0] id_reg1_3, id_reg2_3, ex_reg1_3, ex_reg2_3;
    logic [4:0]  id_wd3, ex_wd3;
    logic [1:0]  count3;

    id_ex_pipe #(.DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush2),
        .id_valid(id_valid2), .id_ready(id_ready2),
        .id_aluop(id_aluop2), .id_alusel(id_alusel2),
        .id_reg1(id_reg1_2), .id_reg2(id_reg2_2),
        .id_wd(id_wd2), .id_wreg(id_wreg2),
        .ex_valid(ex_valid2), .ex_ready(ex_ready2),
        .ex_aluop(ex_aluop2), .ex_alusel(ex_alusel2),
        .ex_reg1(ex_reg1_2), .ex_reg2(ex_reg2_2),
        .ex_wd(ex_wd2), .ex_wreg(ex_wreg2), .count(count2)
    );

    id_ex_pipe #(.DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .flush(flush3),
        .id_valid(id_valid3), .id_ready(id_ready3),
        .id_aluop(id_aluop3), .id_alusel(id_alusel3),
        .id_reg1(id_reg1_3), .id_reg2(id_reg2_3),
        .id_wd(id_wd3), .id_wreg(id_wreg3),
        .ex_valid(ex_valid3), .ex_ready(ex_ready3),
        .ex_aluop(ex_aluop3), .ex_alusel(ex_alusel3),
        .ex_reg1(ex_reg1_3), .ex_reg2(ex_reg2_3),
        .ex_wd(ex_wd3), .ex_wreg(ex_wreg3), .count(count3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        valid, ready, flush;
        logic [7:0]  aluop;
        logic [31:0] reg1;
        logic [4:0]  wd;
        logic        wreg;
        logic        e_valid, e_ready;
        logic [1:0]  e_count;
        logic [7:0]  e_aluop;
        logic [31:0] e_reg1;
        logic [4:0]  e_wd;
        logic        e_wreg;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic v, input logic r, input logic f, input logic [7:0] op, input logic [31:0] r1,
        input logic [4:0] wd, input logic wr,
        input logic ev, input logic er, input logic [1:0] ec, input logic [7:0] eop,
        input logic [31:0] er1, input logic [4:0] ewd, input logic ewr);
        vec_t t;
        t.valid = v; t.ready = r; t.flush = f; t.aluop = op; t.reg1 = r1; t.wd = wd; t.wreg = wr;
        t.e_valid = ev; t.e_ready = er; t.e_count = ec; t.e_aluop = eop;
        t.e_reg1 = er1; t.e_wd = ewd; t.e_wreg = ewr;
        return t;
    endfunction

    task automatic check_dut2(input string tag, input vec_t t);
        chk({tag, ".ex_valid"},  ex_valid2,  t.e_valid);
        chk({tag, ".id_ready"},  id_ready2,  t.e_ready);
        chk({tag, ".count"},     count2,     t.e_count);
        chk({tag, ".ex_aluop"},  ex_aluop2,  t.e_aluop);
        chk({tag, ".ex_alusel"}, ex_alusel2, t.e_valid ? {29'd0, t.e_aluop[2:0]} : 32'd0);
        chk({tag, ".ex_reg1"},   ex_reg1_2,  t.e_reg1);
        chk({tag, ".ex_reg2"},   ex_reg2_2,  t.e_valid ? ~t.e_reg1 : 32'd0);
        chk({tag, ".ex_wd"},     ex_wd2,     t.e_wd);
        chk({tag, ".ex_wreg"},   ex_wreg2,   t.e_wreg);
    endtask

    int q3[$];
    int seq, pushes;
    logic v3, r3, do_push, do_pop;
    vec_t rst_exp;

    initial begin
        rst = 1'b1;
        {flush2, id_valid2, ex_ready2, id_wreg2} = '0;
        {id_aluop2, id_alusel2, id_reg1_2, id_reg2_2, id_wd2} = '0;
        {flush3, id_valid3, ex_ready3, id_wreg3} = '0;
        {id_aluop3, id_alusel3, id_reg1_3, id_reg2_3, id_wd3} = '0;

        // v  r  f  op     reg1   wd  wr | ev er cnt eop    ereg1  ewd ewr
        vecs.push_back(mk(0, 0, 0, 8'h00, 32'h00, 5'd0, 0, 0, 1, 2'd0, 8'h00, 32'h00, 5'd0, 0)); // idle
        vecs.push_back(mk(0, 0, 0, 8'h00, 32'h00, 5'd0, 0, 0, 1, 2'd0, 8'h00, 32'h00, 5'd0, 0));
        vecs.push_back(mk(1, 0, 0, 8'h01, 32'h11, 5'd1, 1, 1, 1, 2'd1, 8'h01, 32'h11, 5'd1, 1)); // A
        vecs.push_back(mk(1, 0, 0, 8'h02, 32'h22, 5'd2, 1, 1, 0, 2'd2, 8'h01, 32'h11, 5'd1, 1)); // B, full
        vecs.push_back(mk(1, 0, 0, 8'h03, 32'h33, 5'd3, 1, 1, 0, 2'd2, 8'h01, 32'h11, 5'd1, 1)); // C refused
        vecs.push_back(mk(1, 1, 0, 8'h03, 32'h33, 5'd3, 1, 1, 1, 2'd1, 8'h02, 32'h22, 5'd2, 1)); // pop A only
        vecs.push_back(mk(1, 1, 0, 8'h03, 32'h33, 5'd3, 1, 1, 1, 2'd1, 8'h03, 32'h33, 5'd3, 1)); // pop B push C
        vecs.push_back(mk(0, 1, 0, 8'h00, 32'h00, 5'd0, 0, 0, 1, 2'd0, 8'h00, 32'h00, 5'd0, 0)); // drain C
        for (int k = 0; k < 5; k++) begin : b2b
            logic [7:0] op;
            op = 8'h40 + 8'(k);
            vecs.push_back(mk(1, 1, 0, op, 32'h100 + 32'(k), 5'(k + 10), 1,
                              1, 1, 2'd1, op, 32'h100 + 32'(k), 5'(k + 10), 1));
        end
        vecs.push_back(mk(0, 1, 0, 8'h00, 32'h00, 5'd0, 0, 0, 1, 2'd0, 8'h00, 32'h00, 5'd0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h09, 32'h99, 5'd0, 1, 1, 1, 2'd1, 8'h09, 32'h99, 5'd0, 0)); // x0
        vecs.push_back(mk(1, 1, 0, 8'h0a, 32'h55, 5'd5, 1, 1, 1, 2'd1, 8'h0a, 32'h55, 5'd5, 1)); // x5
        vecs.push_back(mk(0, 1, 0, 8'h00, 32'h00, 5'd0, 0, 0, 1, 2'd0, 8'h00, 32'h00, 5'd0, 0));
        vecs.push_back(mk(1, 0, 0, 8'h21, 32'hE0, 5'd7, 1, 1, 1, 2'd1, 8'h21, 32'hE0, 5'd7, 1)); // E
        vecs.push_back(mk(1, 0, 0, 8'h22, 32'hF0, 5'd8, 1, 1, 0, 2'd2, 8'h21, 32'hE0, 5'd7, 1)); // F, full
        vecs.push_back(mk(1, 0, 1, 8'h23, 32'hA0, 5'd9, 1, 0, 1, 2'd0, 8'h00, 32'h00, 5'd0, 0)); // flush + G
        vecs.push_back(mk(0, 0, 0, 8'h00, 32'h00, 5'd0, 0, 0, 1, 2'd0, 8'h00, 32'h00, 5'd0, 0)); // G absent
        vecs.push_back(mk(1, 0, 0, 8'h24, 32'hB0, 5'd4, 1, 1, 1, 2'd1, 8'h24, 32'hB0, 5'd4, 1)); // H
        vecs.push_back(mk(0, 1, 1, 8'h00, 32'h00, 5'd0, 0, 0, 1, 2'd0, 8'h00, 32'h00, 5'd0, 0)); // flush wins pop

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rst_exp = mk(0, 0, 0, 8'h00, 32'h00, 5'd0, 0, 0, 1, 2'd0, 8'h00, 32'h00, 5'd0, 0);
        check_dut2("reset", rst_exp);
        chk("reset3.ex_valid", ex_valid3, 0);
        chk("reset3.id_ready", id_ready3, 1);
        chk("reset3.count", count3, 0);

        foreach (vecs[i]) begin
            id_valid2  = vecs[i].valid;
            ex_ready2  = vecs[i].ready;
            flush2     = vecs[i].flush;
            id_aluop2  = vecs[i].aluop;
            id_alusel2 = vecs[i].aluop[2:0];
            id_reg1_2  = vecs[i].reg1;
            id_reg2_2  = ~vecs[i].reg1;
            id_wd2     = vecs[i].wd;
            id_wreg2   = vecs[i].wreg;
            @(posedge clk);
            #1;
            check_dut2($sformatf("vec%0d", i), vecs[i]);
        end

        // DEPTH 3: random ex_ready against a queue model, across pointer wrap
        seq = 1;
        pushes = 0;
        for (int cyc = 0; cyc < 300 && (pushes < 10 || q3.size() != 0); cyc++) begin
            chk("d3.ex_valid", ex_valid3, q3.size() != 0);
            chk("d3.count", count3, q3.size());
            chk("d3.id_ready", id_ready3, q3.size() < 3);
            if (q3.size() != 0) chk("d3.ex_reg1", ex_reg1_3, q3[0]);
            v3 = (pushes < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
            r3 = 1'($urandom_range(0, 1));
            id_valid3  = v3;
            ex_ready3  = r3;
            id_reg1_3  = seq;
            id_aluop3  = 8'(seq);
            id_wd3     = 5'((seq % 31) + 1);
            id_wreg3   = 1'b1;
            do_push = v3 && (q3.size() < 3);
            do_pop  = r3 && (q3.size() != 0);
            @(posedge clk);
            #1;
            if (do_pop) void'(q3.pop_front());
            if (do_push) begin
                q3.push_back(seq);
                seq++;
                pushes++;
            end
        end
        chk("d3.pushes_done", pushes, 10);
        chk("d3.drained_valid", ex_valid3, 0);
        chk("d3.drained_count", count3, 0);
        id_valid3 = 1'b0;
        ex_ready3 = 1'b0;

        // reset mid-stream drops buffered entries
        id_valid2 = 1'b1; ex_ready2 = 1'b0; flush2 = 1'b0;
        id_reg1_2 = 32'h77; id_wd2 = 5'd3; id_wreg2 = 1'b1; id_aluop2 = 8'h31;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst.count", count2, 2);
        id_valid2 = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_dut2("midrst", rst_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

Parametrised ID/EX pipeline stage that replaces the fixed single register with an elastic, valid/ready-handshaked buffer of DEPTH entries. It sits between decode and execute. It adds:
- backpressure from EX;
- a synchronous flush for branch/jump redirect;
- x0 write suppression;
- NOP-valued outputs whenever no instruction is presented.

## Interface
Parameters:
- XLEN, 32, operand width (ex_reg1/ex_reg2)
- REG_ADDR_W, 5, destination register address width
- ALU_OP_W, 8, ALU opcode width
- ALU_SEL_W, 3, ALU result-select width
- DEPTH, 2, buffer entries; legal range 1..8, any integer (not only powers of 2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all buffered entries and the current input
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  stage can accept an instruction this cycle
- id_aluop  in  ALU_OP_W  ALU opcode
- id_alusel  in  ALU_SEL_W  result select
- id_reg1, id_reg2  in  XLEN  operands
- id_wd  in  REG_ADDR_W  destination register
- id_wreg  in  1  write-enable
- ex_valid  out  1  head entry presented to EX
- ex_ready  in  1  EX consumes head entry
- ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg  out  matching widths  head entry fields
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Push when id_valid && id_ready && !flush. Pop when ex_valid && ex_ready && !flush.
- id_ready = (count < DEPTH). It depends on registered state only; there is no combinational path from ex_ready to id_ready.
- A simultaneous push and pop is only possible when not full. It leaves count unchanged and advances both pointers.
- Write pointer and read pointer wrap explicitly from DEPTH-1 to 0. There is no power-of-2 masking.
- At push, a stored entry has wreg = id_wreg && (id_wd != 0). Writes to x0 never reach EX.
- ex_valid = (count != 0).
- When count == 0, all ex_* fields show NOP values:
  - ex_aluop = EXE_NOP_OP, ex_alusel = EXE_RES_NOP;
  - ex_reg1 = ex_reg2 = 0;
  - ex_wd = NOP_REG_ADDR;
  - ex_wreg = 0.
- When count != 0, ex_* fields show the entry at the read pointer.
- Flush sets count, the read pointer and the write pointer to 0 in the next cycle. The push and pop of the flush cycle are suppressed. Entry storage contents are don't-care.
- Priority: rst > flush > push/pop.
- Under rst, outputs take the reset values below from the next edge on.

## Timing
- Reset values: ex_valid 0, id_ready 1, count 0, ex_* fields at the NOP values listed above.
- Latency: 1 cycle. An instruction pushed at edge N is visible on ex_* with ex_valid = 1 after edge N. There is no same-cycle bypass.
- Throughput: 1 instruction/cycle sustained when ex_ready is held at 1. This holds for any DEPTH ≥ 1 only if pop and push coexist. With DEPTH = 1 and a full buffer, id_ready = 0 in that cycle, so DEPTH = 1 gives half throughput by design.
- Boundaries:
  - Full: id_valid is ignored; no state change on the input side.
  - Empty: ex_ready is ignored.
  - Flush while full: id_ready = 1 from the next cycle.
  - rst mid-stream: all entries are lost.
- Outputs change only on the rising clk edge. Flush affects outputs on the cycle after its assertion.

## Structure
- The shared defines/package holds:
  - EXE_NOP_OP, EXE_RES_NOP, NOP_REG_ADDR, ZERO_32;
  - ALU_OP_BUS, ALU_SEL_BUS, REG_BUS, REG_ADDR_BUS width macros;
  - ENABLE/DISABLE.
- One sub-module: pipe_fifo. It is a generic synchronous FIFO with parameters WIDTH and DEPTH. Ports: clk, rst, clr, push, pop, din, dout, count, full, empty.
- id_ex_pipe does three things around pipe_fifo:
  - packs fields into a single payload of width ALU_OP_W + ALU_SEL_W + 2*XLEN + REG_ADDR_W + 1;
  - applies x0 suppression;
  - muxes NOP values onto ex_* when empty.

## Test plan
- Reset then idle. Checks, all cycles:
  - id_ready = 1, ex_valid = 0, count = 0;
  - ex_aluop = EXE_NOP_OP;
  - ex_wd = 0, ex_wreg = 0.
- DEPTH = 2, ex_ready = 0, push A (reg1 = 0x11), B (reg1 = 0x22), C.
  - After edge 2: count = 2, id_ready = 0, C not accepted.
  - Raise ex_ready: EX sees A, then B, then C. C must be re-presented by decode.
- ex_ready = 1, push 5 back-to-back instructions. Checks:
  - each appears on ex_* exactly 1 cycle later;
  - count stays at 1;
  - no bubble.
- Push id_wd = 0, id_wreg = 1 -> ex_wreg = 0 and ex_wd = 0. Push id_wd = 5, id_wreg = 1 -> ex_wreg = 1.
- Buffer full (count = 2), assert flush together with id_valid = 1. Next cycle:
  - count = 0, ex_valid = 0, ex_* at NOP values, id_ready = 1;
  - the flushed-cycle input does not appear.
- DEPTH = 3, 10 pushes and pops with random ex_ready. Order preserved across pointer wrap (2 -> 0). count never exceeds 3.
